// File: rtl/mysystem_leds_pkg.sv
// Shared constants for the mysystem LED output-port slave: register map, STATUS bits, PWM width.
package mysystem_leds_pkg;

    localparam logic [2:0] ADDR_DATA       = 3'd0;
    localparam logic [2:0] ADDR_BLINK_MASK = 3'd1;
    localparam logic [2:0] ADDR_PERIOD     = 3'd2;
    localparam logic [2:0] ADDR_STATUS     = 3'd3;
    localparam logic [2:0] ADDR_OUTSET     = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR   = 3'd5;
    localparam logic [2:0] ADDR_DUTY       = 3'd6;

    localparam int unsigned STATUS_PHASE_BIT  = 0;
    localparam int unsigned STATUS_ACTIVE_BIT = 1;

    localparam int unsigned PWM_WIDTH = 8;

endpackage

// File: rtl/mysystem_leds_prescaler.sv
// Blink prescaler: toggles phase every PERIOD cycles; PERIOD of zero parks cnt and phase at 0.
module mysystem_leds_prescaler #(
    parameter int unsigned PRESCALE_WIDTH = 24
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [PRESCALE_WIDTH-1:0] period,
    input  logic                      restart,
    output logic                      phase
);

    logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
    logic                      phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        // A PERIOD write restarts the half-period, so a shrinking PERIOD never strands cnt.
        if (restart || (period == '0)) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q >= (period - PRESCALE_WIDTH'(1))) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + PRESCALE_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/mysystem_leds_ctrl.sv
// Avalon-MM output-port slave with set/clear registers and per-bit blink engine.
// Optional PWM dimming (DUTY register at address 6) when MYSYSTEM_LEDS_CTRL_PWM_EN is defined.
module mysystem_leds_ctrl
    import mysystem_leds_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH     = 10,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE    = '0,
    parameter int unsigned           PRESCALE_WIDTH = 24,
    parameter int unsigned           DEFAULT_PERIOD = 12500000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port
);

    localparam logic [PRESCALE_WIDTH-1:0] PERIOD_RST = PRESCALE_WIDTH'(DEFAULT_PERIOD);

    logic                      wr;
    logic [DATA_WIDTH-1:0]     wd;
    logic                      unused_wd;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic [DATA_WIDTH-1:0]     blink_mask_q, blink_mask_d;
    logic [PRESCALE_WIDTH-1:0] period_q, period_d;
    logic [DATA_WIDTH-1:0]     out_q, out_d;
    logic [DATA_WIDTH-1:0]     eff;
    logic                      phase;
    logic                      period_wr;

    assign wr        = chipselect & ~write_n;
    assign wd        = writedata[DATA_WIDTH-1:0];
    assign unused_wd = ^writedata;
    assign period_wr = wr && (address == ADDR_PERIOD);

    mysystem_leds_prescaler #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .period  (period_q),
        .restart (period_wr),
        .phase   (phase)
    );

    assign eff = data_q & ~(blink_mask_q & {DATA_WIDTH{phase}});

`ifdef MYSYSTEM_LEDS_CTRL_PWM_EN
    logic [PWM_WIDTH-1:0] duty_q, duty_d;
    logic [PWM_WIDTH-1:0] pwm_cnt_q, pwm_cnt_d;
    logic                 pwm_on;

    assign pwm_on = (duty_q == {PWM_WIDTH{1'b1}}) || (pwm_cnt_q < duty_q);

    always_comb begin
        duty_d    = duty_q;
        pwm_cnt_d = pwm_cnt_q + PWM_WIDTH'(1);
        if (wr && (address == ADDR_DUTY)) begin
            duty_d = writedata[PWM_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            duty_q    <= {PWM_WIDTH{1'b1}};
            pwm_cnt_q <= '0;
        end else begin
            duty_q    <= duty_d;
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    assign out_d = eff & {DATA_WIDTH{pwm_on}};
`else
    assign out_d = eff;
`endif

    always_comb begin
        data_d       = data_q;
        blink_mask_d = blink_mask_q;
        period_d     = period_q;
        if (wr) begin
            case (address)
                ADDR_DATA:       data_d       = wd;
                ADDR_BLINK_MASK: blink_mask_d = wd;
                ADDR_PERIOD:     period_d     = writedata[PRESCALE_WIDTH-1:0];
                ADDR_OUTSET:     data_d       = data_q | wd;
                ADDR_OUTCLEAR:   data_d       = data_q & ~wd;
                default:         ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q       <= RESET_VALUE;
            blink_mask_q <= '0;
            period_q     <= PERIOD_RST;
            out_q        <= RESET_VALUE;
        end else begin
            data_q       <= data_d;
            blink_mask_q <= blink_mask_d;
            period_q     <= period_d;
            out_q        <= out_d;
        end
    end

    assign out_port = out_q;

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:       readdata[DATA_WIDTH-1:0]     = data_q;
            ADDR_BLINK_MASK: readdata[DATA_WIDTH-1:0]     = blink_mask_q;
            ADDR_PERIOD:     readdata[PRESCALE_WIDTH-1:0] = period_q;
            ADDR_STATUS: begin
                readdata[STATUS_PHASE_BIT]  = phase;
                readdata[STATUS_ACTIVE_BIT] = (period_q != '0);
            end
`ifdef MYSYSTEM_LEDS_CTRL_PWM_EN
            ADDR_DUTY:       readdata[PWM_WIDTH-1:0]      = duty_q;
`endif
            default:         ;
        endcase
    end

endmodule

// File: tb/tb_mysystem_leds_ctrl.sv
// Directed self-checking bench for mysystem_leds_ctrl (DATA_WIDTH=10, RESET_VALUE=0x2A5).
module tb_mysystem_leds_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [9:0]  out_port;

    int n_checks = 0;
    int n_errors = 0;

    mysystem_leds_ctrl #(
        .DATA_WIDTH     (10),
        .RESET_VALUE    (10'h2A5),
        .PRESCALE_WIDTH (24),
        .DEFAULT_PERIOD (12500000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Single-cycle write; returns 1ns after the edge that sampled it.
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    logic [31:0] rd;
    logic [9:0]  exp_out;
    int          on_cnt;
    int          off_cnt;

    initial begin
        reset      = 1'b1;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        tick(3);
        reset = 1'b0;

        // Reset state
        check_eq("rst_out", {22'd0, out_port}, 32'h2A5);
        bus_read(3'd0, rd); check_eq("rst_data", rd, 32'h2A5);
        bus_read(3'd3, rd); check_eq("rst_status", rd, 32'h2);
        bus_read(3'd1, rd); check_eq("rst_mask", rd, 32'h0);
        bus_read(3'd2, rd); check_eq("rst_period", rd, 32'd12500000);
        bus_read(3'd4, rd); check_eq("outset_reads0", rd, 32'h0);
        bus_read(3'd5, rd); check_eq("outclr_reads0", rd, 32'h0);
`ifdef MYSYSTEM_LEDS_CTRL_PWM_EN
        bus_read(3'd6, rd); check_eq("rst_duty", rd, 32'hFF);
`endif

        // DATA / OUTCLEAR / OUTSET, upper writedata bits dropped
        bus_write(3'd0, 32'hFFFF_FFFF);
        bus_read(3'd0, rd); check_eq("data_trunc", rd, 32'h3FF);
        bus_write(3'd5, 32'h0000_000F);
        bus_write(3'd4, 32'h0000_0001);
        bus_read(3'd0, rd); check_eq("data_setclr", rd, 32'h3F1);
        check_eq("out_lag", {22'd0, out_port}, 32'h3F0);
        tick(1);
        check_eq("out_setclr", {22'd0, out_port}, 32'h3F1);

        // Blink: mask low two bits, PERIOD=4 written last (edge E)
        bus_write(3'd1, 32'h003);
        bus_write(3'd0, 32'h3FF);
        bus_write(3'd2, 32'd4);
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            exp_out = ((((k - 1) / 4) % 2) == 1) ? 10'h3FC : 10'h3FF;
            check_eq($sformatf("blink_k%0d", k), {22'd0, out_port}, {22'd0, exp_out});
        end
        bus_read(3'd3, rd); check_eq("status_phase1", rd, 32'h3);

        // PERIOD=0 while phase=1
        bus_write(3'd2, 32'd0);
        bus_read(3'd3, rd); check_eq("status_off", rd, 32'h0);
        check_eq("out_last_masked", {22'd0, out_port}, 32'h3FC);
        tick(1);
        check_eq("out_unmasked", {22'd0, out_port}, 32'h3FF);
        tick(2);
        check_eq("out_hold", {22'd0, out_port}, 32'h3FF);

        // Reset collides with a DATA write mid-blink
        bus_write(3'd2, 32'd4);
        tick(5);
        address    = 3'd0;
        writedata  = 32'h155;
        chipselect = 1'b1;
        write_n    = 1'b0;
        reset      = 1'b1;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        reset      = 1'b0;
        bus_read(3'd0, rd); check_eq("rst_wr_data", rd, 32'h2A5);
        check_eq("rst_wr_out", {22'd0, out_port}, 32'h2A5);
        bus_read(3'd1, rd); check_eq("rst_wr_mask", rd, 32'h0);
        bus_read(3'd2, rd); check_eq("rst_wr_period", rd, 32'd12500000);
        bus_read(3'd3, rd); check_eq("rst_wr_status", rd, 32'h2);
        tick(1);
        check_eq("rst_wr_out2", {22'd0, out_port}, 32'h2A5);

        // Reserved addresses
        bus_write(3'd7, 32'hFFFF_FFFF);
        bus_read(3'd7, rd); check_eq("rsvd7", rd, 32'h0);
`ifdef MYSYSTEM_LEDS_CTRL_PWM_EN
        bus_write(3'd0, 32'h3FF);
        bus_write(3'd6, 32'd64);
        bus_read(3'd6, rd); check_eq("duty_rd", rd, 32'd64);
        on_cnt  = 0;
        off_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            tick(1);
            if (out_port == 10'h3FF) on_cnt++;
            else if (out_port == 10'h000) off_cnt++;
        end
        check_eq("pwm_on64", on_cnt, 64);
        check_eq("pwm_off192", off_cnt, 192);
        bus_write(3'd6, 32'd0);
        tick(1);
        on_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            tick(1);
            if (out_port != 10'h000) on_cnt++;
        end
        check_eq("pwm_duty0", on_cnt, 0);
`else
        bus_write(3'd6, 32'h40);
        bus_read(3'd6, rd); check_eq("addr6_rsvd", rd, 32'h0);
        tick(1);
        check_eq("addr6_out", {22'd0, out_port}, 32'h2A5);
        on_cnt  = 0;
        off_cnt = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mysystem_leds_ctrl.md
Name: mysystem_leds_ctrl

Overview:
Parametrised Avalon-MM output-port slave. It succeeds the fixed 10-bit LED register used in the mysystem Qsys build.
- Adds configurable width and reset value.
- Adds atomic set/clear registers and a per-bit hardware blink engine driven by a programmable prescaler.
- Sits on the HPS/Nios lightweight bus and drives board LEDs or other static outputs.
- Software never has to bit-bang blink timing.

Parameters:
DATA_WIDTH, 10, output port width, legal range 1..32.
RESET_VALUE, 0, value loaded into DATA and driven on out_port after reset.
PRESCALE_WIDTH, 24, width of PERIOD register and prescaler counter, legal range 2..32.
DEFAULT_PERIOD, 12500000, PERIOD reset value in clk cycles per blink half-period; 0 disables blinking.

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
address  in  3  word address.
chipselect  in  1  slave select.
write_n  in  1  active-low write strobe, qualified by chipselect.
writedata  in  32  write data; bits above the target register width are ignored.
readdata  out  32  combinational read data, zero-extended; zero wait states.
out_port  out  DATA_WIDTH  registered output pins.

Behaviour:
- Write strobe: wr = chipselect & ~write_n. No read strobe; readdata is a pure function of address and register state.
- Address map:
  - 0 DATA: RW.
  - 1 BLINK_MASK: RW.
  - 2 PERIOD: RW, PRESCALE_WIDTH bits.
  - 3 STATUS: RO; bit0 = phase, bit1 = blink_active (PERIOD != 0); writes ignored.
  - 4 OUTSET: WO; DATA <= DATA | wd; reads 0.
  - 5 OUTCLEAR: WO; DATA <= DATA & ~wd; reads 0.
  - 6 DUTY: see Optional Feature; reads 0 and ignores writes when the feature is absent.
  - 7: reserved; reads 0, writes ignored.
- Reset (sync, highest priority, overrides any same-cycle write):
  - DATA = RESET_VALUE, BLINK_MASK = 0, PERIOD = DEFAULT_PERIOD.
  - cnt = 0, phase = 0, out_port = RESET_VALUE.
  - Reset mid-blink aborts immediately; the next cycle starts counting from 0.
- Prescaler:
  - If PERIOD == 0: cnt and phase are held at 0.
  - Otherwise, each cycle: if cnt >= PERIOD-1 then cnt <= 0 and phase <= ~phase, else cnt <= cnt+1.
  - Full blink period is 2*PERIOD cycles.
- PERIOD write: takes effect at the write edge and forces cnt <= 0, phase <= 0 in that same edge. Writing a value smaller than the current cnt is therefore safe.
- Effective output: eff = DATA & ~(BLINK_MASK & {DATA_WIDTH{phase}}). Masked bits that are set in DATA turn off during phase 1; masked bits that are clear stay off.
- Output timing: out_port <= eff every cycle. A write sampled at edge E updates its register at E; the new value appears on out_port at E+1, so latency is 1 cycle after the register update.
- DATA_WIDTH < 32: upper writedata bits are dropped and readdata upper bits read 0.
- Phase toggle coinciding with a DATA/OUTSET/OUTCLEAR write: both take effect on the same edge and eff uses the new values of both.

Optional Feature:
Macro MYSYSTEM_LEDS_CTRL_PWM_EN.
- Defined:
  - Adds an 8-bit DUTY register at address 6, RW, reset 255.
  - Adds a free-running 8-bit pwm_cnt (reset 0, wraps 255 -> 0).
  - pwm_on = (DUTY == 255) | (pwm_cnt < DUTY).
  - out_port <= eff & {DATA_WIDTH{pwm_on}}.
  - DUTY == 0 forces all outputs off.
- Undefined: none of this logic exists; address 6 behaves as reserved and out_port <= eff.

Decomposition:
- Shared package mysystem_leds_pkg holds:
  - address constants ADDR_DATA..ADDR_DUTY (3 bits);
  - STATUS bit indices;
  - PWM_WIDTH = 8.
- One natural sub-module: mysystem_leds_prescaler.
  - Parameter PRESCALE_WIDTH.
  - Inputs clk, reset, period, restart; output phase.
- Register file, read mux and output register stay in the top module.

Test Plan:
1. Reset with RESET_VALUE=10'h2A5 -> out_port = 0x2A5 and readdata at addr 0 = 0x2A5 on the cycle after reset deasserts; STATUS = 0x2 (blink_active).
2. Write DATA=0x3FF, then OUTCLEAR=0x00F, then OUTSET=0x001 -> DATA reads 0x3F1; out_port = 0x3F1 one cycle after the last write.
3. PERIOD=4, BLINK_MASK=0x003, DATA=0x3FF -> out_port alternates 0x3FF / 0x3FC every 4 cycles; first drop occurs 5 cycles after the PERIOD write edge.
4. PERIOD=0 while phase=1 -> phase reads 0 next cycle and out_port returns to DATA; STATUS = 0x0.
5. Assert reset for one cycle in the same cycle as a DATA write of 0x155 mid-blink -> write lost, DATA = RESET_VALUE, cnt restarts at 0.
6. With MYSYSTEM_LEDS_CTRL_PWM_EN, DUTY=64, DATA=0x3FF, BLINK_MASK=0 -> out_port = 0x3FF for 64 of every 256 cycles; DUTY=0 gives constant 0; without the macro, addr 6 reads 0.
